// File: rtl/counter_pkg.sv
// Shared types and constants for the tens-stage counter and its display helpers.
// Seven-segment patterns are active-low, bit order gfedcba.
package counter_pkg;

    localparam int BCD_W = 4;

    typedef enum logic {
        SNAP_IDLE  = 1'b0,
        SNAP_VALID = 1'b1
    } snap_state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG7_0    = 7'b1000000;
    localparam logic [6:0] SEG7_1    = 7'b1111001;
    localparam logic [6:0] SEG7_2    = 7'b0100100;
    localparam logic [6:0] SEG7_3    = 7'b0110000;
    localparam logic [6:0] SEG7_4    = 7'b0011001;
    localparam logic [6:0] SEG7_5    = 7'b0010010;
    localparam logic [6:0] SEG7_6    = 7'b0000010;
    localparam logic [6:0] SEG7_7    = 7'b1111000;
    localparam logic [6:0] SEG7_8    = 7'b0000000;
    localparam logic [6:0] SEG7_9    = 7'b0010000;

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD digit to active-low gfedcba seven-segment pattern.
// Non-decimal codes blank the display.
module seg7_decoder
    import counter_pkg::*;
(
    input  logic [BCD_W-1:0] digit,
    output logic [6:0]       seg_n
);

    always_comb begin
        seg_n = SEG_BLANK;
        case (digit)
            4'd0: seg_n = SEG7_0;
            4'd1: seg_n = SEG7_1;
            4'd2: seg_n = SEG7_2;
            4'd3: seg_n = SEG7_3;
            4'd4: seg_n = SEG7_4;
            4'd5: seg_n = SEG7_5;
            4'd6: seg_n = SEG7_6;
            4'd7: seg_n = SEG7_7;
            4'd8: seg_n = SEG7_8;
            4'd9: seg_n = SEG7_9;
            default: seg_n = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/tens_stage_counter.sv
// Tens BCD digit driven by the units-stage carry, with a snapshot handshake port.
// Define TENS_STAGE_SEG7_EN to add the registered seven-segment output seg_n.
module tens_stage_counter
    import counter_pkg::*;
#(
    parameter int MODULUS = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 carry_in,
    input  logic [BCD_W-1:0]     units_in,
    input  logic                 clear,
    input  logic                 snap_req,
    input  logic                 snap_ack,
    output logic [BCD_W-1:0]     tens,
    output logic                 carry_out,
    output logic                 snap_valid,
    output logic [2*BCD_W-1:0]   snap_value
`ifdef TENS_STAGE_SEG7_EN
    ,
    output logic [6:0]           seg_n
`endif
);

    localparam logic [BCD_W-1:0] TENS_LAST = BCD_W'(MODULUS - 1);

    logic        carry_q;
    logic        inc;
    snap_state_t state;

    // Resetting carry_q high keeps a carry level present at reset release from counting.
    assign inc = carry_in & ~carry_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            carry_q   <= 1'b1;
            tens      <= '0;
            carry_out <= 1'b0;
        end else begin
            carry_q <= carry_in;
            if (clear) begin
                tens      <= '0;
                carry_out <= 1'b0;
            end else if (inc && (tens == TENS_LAST)) begin
                tens      <= '0;
                carry_out <= 1'b1;
            end else if (inc) begin
                tens      <= tens + 1'b1;
                carry_out <= 1'b0;
            end else begin
                carry_out <= 1'b0;
            end
        end
    end

    // Snapshot handshake: snap_req in IDLE captures {tens, units_in} on that edge and
    // raises snap_valid; the value stays frozen until snap_ack is seen while valid.
    // snap_ack in IDLE and snap_req while valid are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= SNAP_IDLE;
            snap_valid <= 1'b0;
            snap_value <= '0;
        end else begin
            case (state)
                SNAP_IDLE: begin
                    if (snap_req) begin
                        state      <= SNAP_VALID;
                        snap_valid <= 1'b1;
                        snap_value <= {tens, units_in};
                    end
                end
                SNAP_VALID: begin
                    if (snap_ack) begin
                        state      <= SNAP_IDLE;
                        snap_valid <= 1'b0;
                    end
                end
                default: begin
                    state      <= SNAP_IDLE;
                    snap_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef TENS_STAGE_SEG7_EN
    logic [6:0] seg_next;

    seg7_decoder u_seg7 (
        .digit (tens),
        .seg_n (seg_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_n <= SEG7_0;
        end else begin
            seg_n <= seg_next;
        end
    end
`endif

endmodule

// File: tb/tb_tens_stage_counter.sv
// Directed bench for tens_stage_counter (MODULUS 10 and 6 instances).
// Expected outputs are queued per applied vector and checked by a monitor after each edge.
module tb_tens_stage_counter;

    localparam int W = 22;

    logic       clk = 1'b0;
    logic       rst;
    logic       carry_in;
    logic       carry6;
    logic [3:0] units_in;
    logic       clear;
    logic       snap_req;
    logic       snap_ack;

    logic [3:0] tens;
    logic       carry_out;
    logic       snap_valid;
    logic [7:0] snap_value;
    logic [3:0] tens6;
    logic       carry_out6;
    logic       snap_valid6;
    logic [7:0] snap_value6;
`ifdef TENS_STAGE_SEG7_EN
    logic [6:0] seg_n;
    logic [6:0] seg_n6;
`endif

    logic [W-1:0] exp_q[$];
    int vectors = 0;
    int miscompares = 0;

    // Hand-written active-low gfedcba patterns for digits 0..5.
    logic [6:0] seg_tab[0:5];
    initial begin
        seg_tab[0] = 7'b1000000;
        seg_tab[1] = 7'b1111001;
        seg_tab[2] = 7'b0100100;
        seg_tab[3] = 7'b0110000;
        seg_tab[4] = 7'b0011001;
        seg_tab[5] = 7'b0010010;
    end

    always #5 clk = ~clk;

    tens_stage_counter #(.MODULUS(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .carry_in   (carry_in),
        .units_in   (units_in),
        .clear      (clear),
        .snap_req   (snap_req),
        .snap_ack   (snap_ack),
        .tens       (tens),
        .carry_out  (carry_out),
        .snap_valid (snap_valid),
        .snap_value (snap_value)
`ifdef TENS_STAGE_SEG7_EN
        ,
        .seg_n      (seg_n)
`endif
    );

    tens_stage_counter #(.MODULUS(6)) dut6 (
        .clk        (clk),
        .rst        (rst),
        .carry_in   (carry6),
        .units_in   (4'd0),
        .clear      (1'b0),
        .snap_req   (1'b0),
        .snap_ack   (1'b0),
        .tens       (tens6),
        .carry_out  (carry_out6),
        .snap_valid (snap_valid6),
        .snap_value (snap_value6)
`ifdef TENS_STAGE_SEG7_EN
        ,
        .seg_n      (seg_n6)
`endif
    );

    // Driver: apply one vector after the falling edge and queue the outputs
    // expected after the next rising edge.
    task automatic vec(input logic r, input logic c, input logic clr,
                       input logic req, input logic ack, input logic [3:0] u,
                       input logic m6, input logic [3:0] e_tens, input logic e_cout,
                       input logic e_sv, input logic [7:0] e_sval, input logic [6:0] e_seg);
        @(negedge clk);
        rst      = r;
        carry_in = m6 ? 1'b0 : c;
        carry6   = m6 ? c : 1'b0;
        clear    = clr;
        snap_req = req;
        snap_ack = ack;
        units_in = u;
        exp_q.push_back({m6, e_tens, e_cout, e_sv, e_sval, e_seg});
    endtask

    // Monitor: one queued expectation per rising edge.
    always @(posedge clk) begin
        logic [W-1:0] e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (e[21]) begin
                if (tens6 !== e[20:17] || carry_out6 !== e[16]) begin
                    miscompares++;
                    $display("FAIL mod6 vec %0d: tens=%0d carry_out=%0b, expected tens=%0d carry_out=%0b",
                             vectors, tens6, carry_out6, e[20:17], e[16]);
                end
`ifdef TENS_STAGE_SEG7_EN
                if (seg_n6 !== e[6:0]) begin
                    miscompares++;
                    $display("FAIL seg_n vec %0d: got %b expected %b", vectors, seg_n6, e[6:0]);
                end
`endif
            end else begin
                if (tens !== e[20:17] || carry_out !== e[16] ||
                    snap_valid !== e[15] || snap_value !== e[14:7]) begin
                    miscompares++;
                    $display("FAIL main vec %0d: tens=%0d cout=%0b sv=%0b sval=%h, expected tens=%0d cout=%0b sv=%0b sval=%h",
                             vectors, tens, carry_out, snap_valid, snap_value,
                             e[20:17], e[16], e[15], e[14:7]);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; carry_in = 1'b0; carry6 = 1'b0; units_in = 4'd0;
        clear = 1'b0; snap_req = 1'b0; snap_ack = 1'b0;

        // Reset state.
        vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 7'h00);
        vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 7'h00);
        vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 7'h00);

        // Ten single-cycle pulses: 1..9 then wrap to 0 with carry_out.
        for (int k = 1; k <= 10; k++) begin
            vec(0, 1, 0, 0, 0, 0, 0, 4'(k % 10), (k == 10), 0, 8'h00, 7'h00);
            for (int j = 0; j < 9; j++)
                vec(0, 0, 0, 0, 0, 0, 0, 4'(k % 10), 0, 0, 8'h00, 7'h00);
        end

        // Level held 5 cycles: exactly one increment.
        for (int j = 0; j < 5; j++)
            vec(0, 1, 0, 0, 0, 0, 0, 4'd1, 0, 0, 8'h00, 7'h00);
        vec(0, 0, 0, 0, 0, 0, 0, 4'd1, 0, 0, 8'h00, 7'h00);

        // carry_in high across reset release is not counted.
        vec(1, 1, 0, 0, 0, 0, 0, 4'd0, 0, 0, 8'h00, 7'h00);
        vec(1, 1, 0, 0, 0, 0, 0, 4'd0, 0, 0, 8'h00, 7'h00);
        for (int j = 0; j < 3; j++)
            vec(0, 1, 0, 0, 0, 0, 0, 4'd0, 0, 0, 8'h00, 7'h00);
        vec(0, 0, 0, 0, 0, 0, 0, 4'd0, 0, 0, 8'h00, 7'h00);

        // Count to 4, then clear on a rising edge: clear wins.
        vec(0, 1, 0, 0, 0, 0, 0, 4'd1, 0, 0, 8'h00, 7'h00);
        vec(0, 0, 0, 0, 0, 0, 0, 4'd1, 0, 0, 8'h00, 7'h00);
        vec(0, 1, 0, 0, 0, 0, 0, 4'd2, 0, 0, 8'h00, 7'h00);
        vec(0, 0, 0, 0, 0, 0, 0, 4'd2, 0, 0, 8'h00, 7'h00);
        vec(0, 1, 0, 0, 0, 0, 0, 4'd3, 0, 0, 8'h00, 7'h00);
        vec(0, 0, 0, 0, 0, 0, 0, 4'd3, 0, 0, 8'h00, 7'h00);
        vec(0, 1, 0, 0, 0, 0, 0, 4'd4, 0, 0, 8'h00, 7'h00);
        vec(0, 0, 0, 0, 0, 0, 0, 4'd4, 0, 0, 8'h00, 7'h00);
        vec(0, 1, 1, 0, 0, 0, 0, 4'd0, 0, 0, 8'h00, 7'h00);
        vec(0, 0, 0, 0, 0, 0, 0, 4'd0, 0, 0, 8'h00, 7'h00);

        // Bring tens to 3.
        vec(0, 1, 0, 0, 0, 0, 0, 4'd1, 0, 0, 8'h00, 7'h00);
        vec(0, 0, 0, 0, 0, 0, 0, 4'd1, 0, 0, 8'h00, 7'h00);
        vec(0, 1, 0, 0, 0, 0, 0, 4'd2, 0, 0, 8'h00, 7'h00);
        vec(0, 0, 0, 0, 0, 0, 0, 4'd2, 0, 0, 8'h00, 7'h00);
        vec(0, 1, 0, 0, 0, 0, 0, 4'd3, 0, 0, 8'h00, 7'h00);
        vec(0, 0, 0, 0, 0, 0, 0, 4'd3, 0, 0, 8'h00, 7'h00);

        // Snapshot {3,7}, frozen across three more pulses, then ack.
        vec(0, 0, 0, 1, 0, 7, 0, 4'd3, 0, 1, 8'h37, 7'h00);
        vec(0, 0, 0, 0, 0, 2, 0, 4'd3, 0, 1, 8'h37, 7'h00);
        vec(0, 1, 0, 0, 0, 1, 0, 4'd4, 0, 1, 8'h37, 7'h00);
        vec(0, 0, 0, 0, 0, 8, 0, 4'd4, 0, 1, 8'h37, 7'h00);
        vec(0, 1, 0, 0, 0, 3, 0, 4'd5, 0, 1, 8'h37, 7'h00);
        vec(0, 0, 0, 0, 0, 4, 0, 4'd5, 0, 1, 8'h37, 7'h00);
        vec(0, 1, 0, 0, 0, 9, 0, 4'd6, 0, 1, 8'h37, 7'h00);
        vec(0, 0, 0, 0, 0, 0, 0, 4'd6, 0, 1, 8'h37, 7'h00);
        vec(0, 0, 0, 0, 1, 0, 0, 4'd6, 0, 0, 8'h37, 7'h00);
        vec(0, 0, 0, 0, 0, 0, 0, 4'd6, 0, 0, 8'h37, 7'h00);

        // snap_ack in IDLE ignored; units_in above 9 captured verbatim.
        vec(0, 0, 0, 0, 1, 0, 0, 4'd6, 0, 0, 8'h37, 7'h00);
        vec(0, 0, 0, 1, 0, 4'hC, 0, 4'd6, 0, 1, 8'h6C, 7'h00);
        vec(0, 0, 0, 0, 0, 0, 0, 4'd6, 0, 1, 8'h6C, 7'h00);

        // Reset while VALID clears everything on the same edge.
        vec(1, 0, 0, 0, 0, 0, 0, 4'd0, 0, 0, 8'h00, 7'h00);
        vec(0, 0, 0, 0, 0, 0, 0, 4'd0, 0, 0, 8'h00, 7'h00);

        // snap_req together with snap_ack in VALID: return to IDLE, no recapture.
        vec(0, 0, 0, 1, 0, 5, 0, 4'd0, 0, 1, 8'h05, 7'h00);
        vec(0, 1, 0, 0, 0, 0, 0, 4'd1, 0, 1, 8'h05, 7'h00);
        vec(0, 0, 0, 1, 1, 9, 0, 4'd1, 0, 0, 8'h05, 7'h00);
        vec(0, 0, 0, 0, 0, 9, 0, 4'd1, 0, 0, 8'h05, 7'h00);

        // MODULUS=6 instance: 1..5 then wrap; seg_n lags tens by one edge.
        for (int k = 1; k <= 6; k++) begin
            vec(0, 1, 0, 0, 0, 0, 1, 4'(k % 6), (k == 6), 0, 8'h00, seg_tab[k - 1]);
            vec(0, 0, 0, 0, 0, 0, 1, 4'(k % 6), 0, 0, 8'h00, seg_tab[k % 6]);
        end

        for (int j = 0; j < 20 && exp_q.size() > 0; j++)
            @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
